// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//   Shares one stage-2 ALU/shifter between N_REQ requesters. Only one
//   operation is in flight at a time:
//   IDLE -> ISSUE (ALU enable for one cycle) -> WAIT (ALU result valid)
//   -> RESP (result held until the owner acknowledges) -> IDLE.
//
//   Build option:
//     ALU_ARB_FIXED_PRIORITY_EN  defined   : fixed priority, the lowest index wins
//                                undefined : rotating round-robin
//
//   Ports
//     clk, rst        : clock, synchronous active-high reset
//     req             : per-requester request level, held until gnt
//     req_shift       : per-requester 1 = shift op, 0 = arith/logic op
//     req_opselect    : per-requester 3-bit opselect, requester i at [3i+2:3i]
//     req_operation   : per-requester 3-bit operation, requester i at [3i+2:3i]
//     req_a / req_b   : per-requester DATA_W operands
//     req_shamt       : per-requester 5-bit shift amount
//     gnt             : one-hot, one-cycle pulse when operands are latched
//     rsp_valid       : one-hot, result available for the owner
//     rsp_ack         : per-requester result consume
//     rsp_data/carry  : captured ALU result
//     busy            : high whenever the FSM is not IDLE
//     enable_arith, enable_shift, opselect, operation,
//     aluin1, aluin2, shift_number : ALU control and operands
//     aluout, carry   : ALU result, registered inside the ALU
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_shift,
  input  logic [3*N_REQ-1:0]        req_opselect,
  input  logic [3*N_REQ-1:0]        req_operation,
  input  logic [DATA_W*N_REQ-1:0]   req_a,
  input  logic [DATA_W*N_REQ-1:0]   req_b,
  input  logic [5*N_REQ-1:0]        req_shamt,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ack,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_carry,
  output logic                      busy,
  output logic                      enable_arith,
  output logic                      enable_shift,
  output logic [2:0]                opselect,
  output logic [2:0]                operation,
  output logic [DATA_W-1:0]         aluin1,
  output logic [DATA_W-1:0]         aluin2,
  output logic [4:0]                shift_number,
  input  logic [DATA_W-1:0]         aluout,
  input  logic                      carry
);

  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e               state_q,     state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [N_REQ-1:0]     gnt_q,       gnt_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q,  rsp_data_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic                 busy_q,      busy_d;
  logic                 en_arith_q,  en_arith_d;
  logic                 en_shift_q,  en_shift_d;
  logic [OP_W-1:0]      opselect_q,  opselect_d;
  logic [OP_W-1:0]      operation_q, operation_d;
  logic [DATA_W-1:0]    aluin1_q,    aluin1_d;
  logic [DATA_W-1:0]    aluin2_q,    aluin2_d;
  logic [SHAMT_W-1:0]   shamt_q,     shamt_d;

  logic                 win_found_c;
  logic [IDX_W-1:0]     win_idx_c;

`ifndef ALU_ARB_FIXED_PRIORITY_EN
  // Candidate k of the rotating search that starts just after base.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int unsigned    k);
    return IDX_W'((32'(base) + 32'd1 + k) % N_REQ);
  endfunction
`endif

  // Winner selection among pending requests.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!win_found_c && req[k]) begin
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'(k);
      end
    end
`else
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!win_found_c && req[rr_index(last_grant_q, k)]) begin
        win_found_c = 1'b1;
        win_idx_c   = rr_index(last_grant_q, k);
      end
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    en_arith_d   = 1'b0;
    en_shift_d   = 1'b0;
    opselect_d   = opselect_q;
    operation_d  = operation_q;
    aluin1_d     = aluin1_q;
    aluin2_d     = aluin2_q;
    shamt_d      = shamt_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found_c) begin
          // Only the winner's slice is sampled, and only on this edge.
          opselect_d   = req_opselect[32'(win_idx_c)*OP_W +: OP_W];
          operation_d  = req_operation[32'(win_idx_c)*OP_W +: OP_W];
          aluin1_d     = req_a[32'(win_idx_c)*DATA_W +: DATA_W];
          aluin2_d     = req_b[32'(win_idx_c)*DATA_W +: DATA_W];
          shamt_d      = req_shamt[32'(win_idx_c)*SHAMT_W +: SHAMT_W];
          en_shift_d   = req_shift[win_idx_c];
          en_arith_d   = ~req_shift[win_idx_c];
          gnt_d        = N_REQ'(1) << win_idx_c;
          last_grant_d = win_idx_c;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ALU registered its result at the end of ISSUE.
        rsp_data_d  = aluout;
        rsp_carry_d = carry;
        rsp_valid_d = N_REQ'(1) << last_grant_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // Acks from anyone but the owner are ignored.
        if (rsp_ack[last_grant_q]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      busy_q       <= 1'b0;
      en_arith_q   <= 1'b0;
      en_shift_q   <= 1'b0;
      opselect_q   <= '0;
      operation_q  <= '0;
      aluin1_q     <= '0;
      aluin2_q     <= '0;
      shamt_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      busy_q       <= busy_d;
      en_arith_q   <= en_arith_d;
      en_shift_q   <= en_shift_d;
      opselect_q   <= opselect_d;
      operation_q  <= operation_d;
      aluin1_q     <= aluin1_d;
      aluin2_q     <= aluin2_d;
      shamt_q      <= shamt_d;
    end
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign busy         = busy_q;
  assign enable_arith = en_arith_q;
  assign enable_shift = en_shift_q;
  assign opselect     = opselect_q;
  assign operation    = operation_q;
  assign aluin1       = aluin1_q;
  assign aluin2       = aluin2_q;
  assign shift_number = shamt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
//   Directed bench for alu_issue_arbiter with N_REQ=2, DATA_W=32. A small
//   registered ALU stand-in answers the arbiter; expected results are queued
//   when an operation is issued and compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;

  localparam logic [2:0] OPSEL_ARITH = 3'b011;
  localparam logic [2:0] OPSEL_SHIFT = 3'b100;
  localparam logic [2:0] OP_ADD      = 3'b000;
  localparam logic [2:0] SH_LEFTLOG  = 3'b000;
  localparam logic [2:0] SH_RGHTLOG  = 3'b001;
  localparam logic [2:0] SH_RGHTART  = 3'b011;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      req_shift;
  logic [3*N-1:0]    req_opselect;
  logic [3*N-1:0]    req_operation;
  logic [DW*N-1:0]   req_a;
  logic [DW*N-1:0]   req_b;
  logic [5*N-1:0]    req_shamt;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ack;
  logic [DW-1:0]     rsp_data;
  logic              rsp_carry;
  logic              busy;
  logic              enable_arith;
  logic              enable_shift;
  logic [2:0]        opselect;
  logic [2:0]        operation;
  logic [DW-1:0]     aluin1;
  logic [DW-1:0]     aluin2;
  logic [4:0]        shift_number;
  logic [DW-1:0]     aluout;
  logic              carry;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  alu_issue_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_shift     (req_shift),
    .req_opselect  (req_opselect),
    .req_operation (req_operation),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_shamt     (req_shamt),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_ack       (rsp_ack),
    .rsp_data      (rsp_data),
    .rsp_carry     (rsp_carry),
    .busy          (busy),
    .enable_arith  (enable_arith),
    .enable_shift  (enable_shift),
    .opselect      (opselect),
    .operation     (operation),
    .aluin1        (aluin1),
    .aluin2        (aluin2),
    .shift_number  (shift_number),
    .aluout        (aluout),
    .carry         (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU stand-in; undecoded ops keep the previous result.
  always @(posedge clk) begin
    if (rst) begin
      aluout <= '0;
      carry  <= 1'b0;
    end else if (enable_arith) begin
      if (operation == OP_ADD) {carry, aluout} <= {1'b0, aluin1} + {1'b0, aluin2};
    end else if (enable_shift) begin
      case (operation)
        SH_LEFTLOG: begin aluout <= aluin1 << shift_number; carry <= 1'b0; end
        SH_RGHTLOG: begin aluout <= aluin1 >> shift_number; carry <= 1'b0; end
        SH_RGHTART: begin aluout <= 32'($signed(aluin1) >>> shift_number); carry <= 1'b0; end
        default: ;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic sh, input logic [2:0] os,
                            input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sa);
    req_shift[i]            = sh;
    req_opselect[3*i +: 3]  = os;
    req_operation[3*i +: 3] = op;
    req_a[DW*i +: DW]       = a;
    req_b[DW*i +: DW]       = b;
    req_shamt[5*i +: 5]     = sa;
  endtask

  task automatic push_exp(input int idx, input logic [31:0] d, input logic c);
    exp_t e;
    e.idx   = idx;
    e.data  = d;
    e.carry = c;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, input int exp_idx);
    logic [N-1:0] oh;
    int n = 0;
    oh = N'(1) << exp_idx;
    while (gnt == '0 && n < 20) begin tick(); n++; end
    check($sformatf("%s_gnt", tag), 64'(gnt), 64'(oh));
  endtask

  task automatic wait_rsp(input string tag);
    exp_t e;
    logic [N-1:0] oh;
    int n = 0;
    while (rsp_valid == '0 && n < 20) begin tick(); n++; end
    check($sformatf("%s_rsp_seen", tag), 64'(rsp_valid != '0), 64'(1));
    check($sformatf("%s_sb_nonempty", tag), 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      oh = N'(1) << e.idx;
      check($sformatf("%s_rsp_valid", tag), 64'(rsp_valid), 64'(oh));
      check($sformatf("%s_rsp_data", tag),  64'(rsp_data),  64'(e.data));
      check($sformatf("%s_rsp_carry", tag), 64'(rsp_carry), 64'(e.carry));
    end
  endtask

  initial begin
    logic [DW-1:0] held_data;
    int            exp_w;

    rst           = 1'b1;
    req           = '0;
    req_shift     = '0;
    req_opselect  = '0;
    req_operation = '0;
    req_a         = '0;
    req_b         = '0;
    req_shamt     = '0;
    rsp_ack       = '0;
    tick();
    tick();

    // Reset state
    check("rst_ctrl", 64'({gnt, rsp_valid, rsp_carry, busy, enable_arith, enable_shift,
                           opselect, operation, shift_number}), 64'(0));
    check("rst_aluin1",   64'(aluin1),   64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));

    // T1: requester 0 ADD 5+7, exact latency
    rst = 1'b0;
    set_fields(0, 1'b0, OPSEL_ARITH, OP_ADD, 32'd5, 32'd7, 5'd0);
    req     = 2'b01;
    rsp_ack = 2'b11;
    tick();
    check("t1_gnt",       64'(gnt),          64'(2'b01));
    check("t1_en_arith",  64'(enable_arith), 64'(1));
    check("t1_en_shift",  64'(enable_shift), 64'(0));
    check("t1_busy",      64'(busy),         64'(1));
    check("t1_aluin1",    64'(aluin1),       64'(5));
    check("t1_aluin2",    64'(aluin2),       64'(7));
    check("t1_opselect",  64'(opselect),     64'(OPSEL_ARITH));
    check("t1_operation", 64'(operation),    64'(OP_ADD));
    push_exp(0, 32'd12, 1'b0);
    req = 2'b00;
    tick();
    check("t1_wait_gnt",   64'(gnt),                          64'(0));
    check("t1_wait_en",    64'({enable_arith, enable_shift}), 64'(0));
    check("t1_wait_valid", 64'(rsp_valid),                    64'(0));
    tick();
    check("t1_cycle3_valid", 64'(rsp_valid), 64'(2'b01));
    wait_rsp("t1");
    tick();
    check("t1_busy_done",  64'(busy),      64'(0));
    check("t1_valid_done", 64'(rsp_valid), 64'(0));

    // T3: requester 1 arithmetic right shift
    set_fields(1, 1'b1, OPSEL_SHIFT, SH_RGHTART, 32'h8000_0000, 32'd0, 5'd4);
    req = 2'b10;
    wait_gnt("t3", 1);
    check("t3_en_shift", 64'(enable_shift), 64'(1));
    check("t3_en_arith", 64'(enable_arith), 64'(0));
    check("t3_shamt",    64'(shift_number), 64'(4));
    push_exp(1, 32'hF800_0000, 1'b0);
    req = 2'b00;
    wait_rsp("t3");
    tick();

    // T2: both requesting continuously, ack held high
    set_fields(0, 1'b0, OPSEL_ARITH, OP_ADD, 32'd10, 32'd20, 5'd0);
    set_fields(1, 1'b0, OPSEL_ARITH, OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd0);
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      exp_w = 0;
`else
      exp_w = g % 2;
`endif
      wait_gnt($sformatf("t2_g%0d", g), exp_w);
      if (exp_w == 0) push_exp(0, 32'd30, 1'b0);
      else            push_exp(1, 32'd1,  1'b1);
      if (g == 3) req = 2'b00;
      wait_rsp($sformatf("t2_g%0d", g));
      tick();
    end

    // T4: ack withheld while requester 0 waits; non-owner ack ignored
    set_fields(1, 1'b0, OPSEL_ARITH, OP_ADD, 32'h1234, 32'd1, 5'd0);
    req     = 2'b10;
    rsp_ack = 2'b00;
    wait_gnt("t4a", 1);
    push_exp(1, 32'h1235, 1'b0);
    set_fields(0, 1'b0, OPSEL_ARITH, OP_ADD, 32'd100, 32'd1, 5'd0);
    req = 2'b01;
    wait_rsp("t4a");
    held_data = rsp_data;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold%0d_valid", k), 64'(rsp_valid), 64'(2'b10));
      check($sformatf("t4_hold%0d_data", k),  64'(rsp_data),  64'(32'h1235));
      check($sformatf("t4_hold%0d_carry", k), 64'(rsp_carry), 64'(0));
      check($sformatf("t4_hold%0d_gnt", k),   64'(gnt),       64'(0));
      if (k == 1) rsp_ack = 2'b01;
      if (k < 4) tick();
    end
    check("t4_data_stable", 64'(rsp_data), 64'(held_data));
    rsp_ack = 2'b10;
    tick();
    check("t4_ack_valid", 64'(rsp_valid), 64'(0));
    check("t4_ack_gnt",   64'(gnt),       64'(0));
    rsp_ack = 2'b11;
    tick();
    check("t4b_gnt", 64'(gnt), 64'(2'b01));
    push_exp(0, 32'd101, 1'b0);
    req = 2'b00;
    wait_rsp("t4b");
    tick();

    // T5: reset during WAIT drops the operation and restores priority
    set_fields(0, 1'b0, OPSEL_ARITH, OP_ADD, 32'd50, 32'd60, 5'd0);
    req = 2'b01;
    wait_gnt("t5a", 0);
    req = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_ctrl", 64'({gnt, rsp_valid, rsp_carry, busy, enable_arith, enable_shift,
                              opselect, operation, shift_number}), 64'(0));
    check("t5_rst_aluin1",   64'(aluin1),   64'(0));
    check("t5_rst_aluin2",   64'(aluin2),   64'(0));
    check("t5_rst_rsp_data", 64'(rsp_data), 64'(0));
    tick();
    check("t5_rst_no_valid", 64'(rsp_valid), 64'(0));
    rst = 1'b0;
    set_fields(0, 1'b0, OPSEL_ARITH, OP_ADD, 32'd1, 32'd2, 5'd0);
    set_fields(1, 1'b0, OPSEL_ARITH, OP_ADD, 32'd9, 32'd9, 5'd0);
    req = 2'b11;
    tick();
    check("t5b_gnt", 64'(gnt), 64'(2'b01));
    push_exp(0, 32'd3, 1'b0);
    req = 2'b00;
    wait_rsp("t5b");
    tick();

    // T6: operands changed after grant have no effect
    set_fields(0, 1'b0, OPSEL_ARITH, OP_ADD, 32'd3, 32'd4, 5'd0);
    req = 2'b01;
    wait_gnt("t6", 0);
    push_exp(0, 32'd7, 1'b0);
    req_a[DW*0 +: DW] = 32'h100;
    req_b[DW*0 +: DW] = 32'h200;
    req = 2'b00;
    tick();
    check("t6_aluin1_held", 64'(aluin1), 64'(3));
    check("t6_aluin2_held", 64'(aluin2), 64'(4));
    wait_rsp("t6");
    tick();
    check("t6_idle_busy", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
